// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer: merges load-use, taken-branch and memory-wait into prioritised pipeline controls.
// Optional stall-cycle counter built only when STALL_PERF_CNT_EN is defined.
module pipeline_stall_controller #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 15,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [4:0]       i_if_id_rs1,
    input  logic [4:0]       i_if_id_rs2,
    input  logic [4:0]       i_id_ex_rd,
    input  logic             i_id_ex_mem_read,
    input  logic             i_ex_branch_taken,
    input  logic             i_mem_busy,
    output logic             o_pc_write,
    output logic             o_if_id_write,
    output logic             o_if_id_flush,
    output logic             o_id_ex_bubble,
    output logic             o_ex_mem_hold,
    output logic [1:0]       o_state,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_count
);

    typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MEM_WAIT = 2'd2} state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LIM  = 8'(MEM_TIMEOUT);

    state_t     state, state_nxt, eff;
    logic [2:0] flush_left, flush_left_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       timeout_q, timeout_nxt;
    logic       hazard, events_ok;

    assign hazard = i_id_ex_mem_read && (i_id_ex_rd != 5'd0) &&
                    ((i_id_ex_rd == i_if_id_rs1) || (i_id_ex_rd == i_if_id_rs2));

    always_comb begin
        state_nxt      = state;
        flush_left_nxt = flush_left;
        wait_cnt_nxt   = 8'd0;
        timeout_nxt    = timeout_q;
        eff            = RUN;
        events_ok      = 1'b1;
        o_pc_write     = 1'b0;
        o_if_id_write  = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_bubble = 1'b0;
        o_ex_mem_hold  = 1'b0;

        if (i_mem_busy) begin
            o_ex_mem_hold = 1'b1;
            state_nxt     = MEM_WAIT;
            wait_cnt_nxt  = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
            if (wait_cnt_nxt >= TIMEOUT_LIM)
                timeout_nxt = 1'b1;
        end else begin
            // Release from MEM_WAIT behaves as the resumed state, but EX was frozen
            // so branch/hazard seen this cycle are stale and ignored.
            case (state)
                MEM_WAIT: begin
                    eff       = (flush_left != 3'd0) ? FLUSH : RUN;
                    events_ok = 1'b0;
                end
                FLUSH:   eff = FLUSH;
                default: eff = RUN;
            endcase

            if (eff == FLUSH) begin
                o_if_id_flush  = 1'b1;
                o_id_ex_bubble = 1'b1;
                o_pc_write     = 1'b1;
                if (events_ok && i_ex_branch_taken)
                    flush_left_nxt = FLUSH_RELOAD;
                else
                    flush_left_nxt = (flush_left != 3'd0) ? flush_left - 3'd1 : 3'd0;
                state_nxt = (flush_left_nxt != 3'd0) ? FLUSH : RUN;
            end else if (events_ok && i_ex_branch_taken) begin
                o_if_id_flush  = 1'b1;
                o_id_ex_bubble = 1'b1;
                o_pc_write     = 1'b1;
                flush_left_nxt = FLUSH_RELOAD;
                state_nxt      = (FLUSH_RELOAD != 3'd0) ? FLUSH : RUN;
            end else if (events_ok && hazard) begin
                o_id_ex_bubble = 1'b1;
                state_nxt      = RUN;
            end else begin
                o_pc_write    = 1'b1;
                o_if_id_write = 1'b1;
                state_nxt     = RUN;
            end
        end

        if (!i_reset_n) begin
            o_pc_write     = 1'b0;
            o_if_id_write  = 1'b0;
            o_if_id_flush  = 1'b1;
            o_id_ex_bubble = 1'b1;
            o_ex_mem_hold  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= RUN;
            flush_left <= 3'd0;
            wait_cnt   <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_left <= flush_left_nxt;
            wait_cnt   <= wait_cnt_nxt;
            timeout_q  <= timeout_nxt;
        end
    end

    assign o_state       = i_reset_n ? state : 2'd0;
    assign o_mem_timeout = timeout_q;

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            stall_cnt <= '0;
        else if (!o_pc_write && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    assign o_stall_count = stall_cnt;
`else
    assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed-vector bench for pipeline_stall_controller; driver queues expectations, negedge monitor checks.
module tb_pipeline_stall_controller;

    localparam int CNT_W = 16;

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold, state[1:0]}
    localparam logic [6:0] IDLE = 7'b1100000;
    localparam logic [6:0] HAZ  = 7'b0001000;
    localparam logic [6:0] BR0  = 7'b1011000;
    localparam logic [6:0] FL1  = 7'b1011001;
    localparam logic [6:0] FLW  = 7'b1011010;
    localparam logic [6:0] BSY0 = 7'b0000100;
    localparam logic [6:0] BSY1 = 7'b0000101;
    localparam logic [6:0] BSYW = 7'b0000110;
    localparam logic [6:0] RELW = 7'b1100010;
    localparam logic [6:0] RST  = 7'b0011000;

    typedef struct packed {
        logic [6:0]       ctl;
        logic             to;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] rs1, rs2, rd;
    logic ld, br, busy;
    logic pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold, mem_timeout;
    logic [1:0] state;
    logic [CNT_W-1:0] stall_count;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;
    logic [CNT_W-1:0] m_cnt = '0;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_if_id_rs1(rs1), .i_if_id_rs2(rs2), .i_id_ex_rd(rd),
        .i_id_ex_mem_read(ld), .i_ex_branch_taken(br), .i_mem_busy(busy),
        .o_pc_write(pc_write), .o_if_id_write(if_id_write), .o_if_id_flush(if_id_flush),
        .o_id_ex_bubble(id_ex_bubble), .o_ex_mem_hold(ex_mem_hold), .o_state(state),
        .o_mem_timeout(mem_timeout), .o_stall_count(stall_count)
    );

    always @(negedge clk) begin
        exp_t  e;
        exp_t  a;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a.ctl = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold, state};
            a.to  = mem_timeout;
            a.cnt = stall_count;
            n_chk++;
            if (a === e)
                n_pass++;
            else
                $display("FAIL %s: ctl=%b to=%b cnt=%0d, expected ctl=%b to=%b cnt=%0d",
                         nm, a.ctl, a.to, a.cnt, e.ctl, e.to, e.cnt);
        end
    end

    task automatic cyc(input string nm, input logic r, input logic bz, input logic b,
                       input logic l, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [6:0] ctl, input logic to);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r; busy = bz; br = b; ld = l; rd = d; rs1 = s1; rs2 = s2;
        e.ctl = ctl;
        e.to  = to;
`ifdef STALL_PERF_CNT_EN
        e.cnt = r ? m_cnt : '0;
        if (!r)
            m_cnt = '0;
        else if (!ctl[6] && m_cnt != '1)
            m_cnt = m_cnt + 1'b1;
`else
        e.cnt = '0;
`endif
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic idle(input string nm, input logic [6:0] ctl, input logic to);
        cyc(nm, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, ctl, to);
    endtask

    initial begin
        rst_n = 1'b0; busy = 0; br = 0; ld = 0; rd = 0; rs1 = 0; rs2 = 0;

        cyc("reset0", 0, 0, 0, 0, 0, 0, 0, RST, 0);
        cyc("reset1", 0, 1, 1, 1, 5, 5, 5, RST, 0);
        idle("run_idle0", IDLE, 0);
        idle("run_idle1", IDLE, 0);

        // load-use variants
        cyc("hazard_rs1", 1, 0, 0, 1, 5'd5, 5'd5, 5'd0, HAZ, 0);
        idle("hazard_single", IDLE, 0);
        cyc("hazard_rd0", 1, 0, 0, 1, 5'd0, 5'd0, 5'd0, IDLE, 0);
        cyc("hazard_rs2", 1, 0, 0, 1, 5'd7, 5'd1, 5'd7, HAZ, 0);
        cyc("no_load", 1, 0, 0, 0, 5'd5, 5'd5, 5'd0, IDLE, 0);
        cyc("rd_mismatch", 1, 0, 0, 1, 5'd6, 5'd5, 5'd4, IDLE, 0);

        // branch: three flush cycles, hazard ignored while flushing
        cyc("br_take", 1, 0, 1, 0, 0, 0, 0, BR0, 0);
        idle("br_flush2", FL1, 0);
        cyc("br_flush3_haz", 1, 0, 0, 1, 5'd5, 5'd5, 5'd0, FL1, 0);
        idle("br_done", IDLE, 0);

        // branch re-taken mid-flush reloads the count
        cyc("rebr_take", 1, 0, 1, 0, 0, 0, 0, BR0, 0);
        idle("rebr_f2", FL1, 0);
        cyc("rebr_again", 1, 0, 1, 0, 0, 0, 0, FL1, 0);
        idle("rebr_f4", FL1, 0);
        idle("rebr_f5", FL1, 0);
        idle("rebr_done", IDLE, 0);

        // branch interrupted by 4 busy cycles
        cyc("bw_take", 1, 0, 1, 0, 0, 0, 0, BR0, 0);
        cyc("bw_busy0", 1, 1, 0, 0, 0, 0, 0, BSY1, 0);
        for (int i = 0; i < 3; i++)
            cyc("bw_busy", 1, 1, 0, 0, 0, 0, 0, BSYW, 0);
        idle("bw_release_flush2", FLW, 0);
        idle("bw_flush3", FL1, 0);
        idle("bw_done", IDLE, 0);

        // priority: busy beats branch and hazard
        cyc("prio_all", 1, 1, 1, 1, 5'd3, 5'd3, 5'd3, BSY0, 0);
        idle("prio_release", RELW, 0);
        idle("prio_done", IDLE, 0);

        // timeout after 15 consecutive busy cycles
        cyc("to_busy0", 1, 1, 0, 0, 0, 0, 0, BSY0, 0);
        for (int i = 1; i < 20; i++)
            cyc("to_busy", 1, 1, 0, 0, 0, 0, 0, BSYW, (i >= 15));
        idle("to_release", RELW, 1);
        idle("to_sticky", IDLE, 1);

        // reset mid-MEM_WAIT abandons it
        cyc("rmw_busy0", 1, 1, 0, 0, 0, 0, 0, BSY0, 1);
        cyc("rmw_busy1", 1, 1, 0, 0, 0, 0, 0, BSYW, 1);
        cyc("rmw_busy2", 1, 1, 0, 0, 0, 0, 0, BSYW, 1);
        cyc("rmw_reset", 0, 1, 0, 0, 0, 0, 0, RST, 0);
        cyc("rmw_reset_hold", 0, 1, 1, 0, 0, 0, 0, RST, 0);
        idle("rmw_after", IDLE, 0);
        cyc("rmw_hazard", 1, 0, 0, 1, 5'd9, 5'd0, 5'd9, HAZ, 0);
        idle("rmw_done", IDLE, 0);

        @(negedge clk);
        #1;
        n_chk++;
        if (exp_q.size() == 0)
            n_pass++;
        else
            $display("FAIL drain: pending=%0d, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
